// File: rtl/maze_pkg.sv
// Shared definitions for the maze path player: grid geometry, move encoding,
// path length limit and the controller state enumeration.
package maze_pkg;

    localparam int GRID_SIZE   = 16;
    localparam int MAX_LEN_DEF = 254;
    localparam int COORD_W     = 4;
    localparam int LEN_W       = 8;

    typedef enum logic [1:0] {
        MOVE_UP    = 2'b00,
        MOVE_RIGHT = 2'b01,
        MOVE_DOWN  = 2'b10,
        MOVE_LEFT  = 2'b11
    } move_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_REQ   = 3'd3,
        ST_APPLY = 3'd4,
        ST_FIN   = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // A path is replayable only if it has at least one move and fits the queue.
    function automatic logic len_is_legal(input logic [LEN_W-1:0] len, input int max_len);
        return (len != '0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/path_player_if.sv
// Command/data bus between the path player (master) and the external move queue (slave).
interface path_player_if;
    import maze_pkg::*;

    // Queue commands are single-cycle strobes with no ready: q_init clears the queue,
    // q_load commits the loaded path, q_deq pops one move whose code appears on
    // q_data the following cycle. q_empty/q_full are level status; at most one
    // strobe is high in any cycle.
    logic [1:0]       q_data;
    logic             q_empty;
    logic             q_full;
    logic             q_init;
    logic             q_load;
    logic             q_deq;
    logic [LEN_W-1:0] q_back;

    modport master (
        input  q_data, q_empty, q_full,
        output q_init, q_load, q_deq, q_back
    );

    modport slave (
        output q_data, q_empty, q_full,
        input  q_init, q_load, q_deq, q_back
    );

endinterface

// File: rtl/maze_step.sv
// Combinational single-move position update on the 16x16 grid, flagging moves
// that would leave the grid instead of wrapping.
module maze_step
    import maze_pkg::*;
(
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    input  move_t              dir,
    output logic [COORD_W-1:0] next_row,
    output logic [COORD_W-1:0] next_col,
    output logic               out_of_bounds
);

    localparam logic [COORD_W-1:0] EDGE_MAX = COORD_W'(GRID_SIZE - 1);

    always_comb begin
        next_row      = row;
        next_col      = col;
        out_of_bounds = 1'b0;
        unique case (dir)
            MOVE_UP: begin
                if (row == '0) out_of_bounds = 1'b1;
                else           next_row      = row - 1'b1;
            end
            MOVE_RIGHT: begin
                if (col == EDGE_MAX) out_of_bounds = 1'b1;
                else                 next_col      = col + 1'b1;
            end
            MOVE_DOWN: begin
                if (row == EDGE_MAX) out_of_bounds = 1'b1;
                else                 next_row      = row + 1'b1;
            end
            MOVE_LEFT: begin
                if (col == '0) out_of_bounds = 1'b1;
                else           next_col      = col - 1'b1;
            end
            default: out_of_bounds = 1'b1;
        endcase
    end

endmodule

// File: rtl/path_player.sv
// Replays a path of moves from an external queue, tracking the position on the
// grid and reporting whether the goal was reached or the path broke.
module path_player
    import maze_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   path_len,
    input  logic [COORD_W-1:0] start_row,
    input  logic [COORD_W-1:0] start_col,
    input  logic [COORD_W-1:0] goal_row,
    input  logic [COORD_W-1:0] goal_col,
    path_player_if.master      q,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic               busy,
    output logic               step,
    output logic               done,
    output logic               reached,
    output logic               error,
    output state_t             dbg_state
);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] goal_row_q, goal_row_d;
    logic [COORD_W-1:0] goal_col_q, goal_col_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic               reached_q, reached_d;

    logic               start_ok;
    logic               path_finished;
    logic [COORD_W-1:0] next_row;
    logic [COORD_W-1:0] next_col;
    logic               out_of_bounds;

    maze_step u_step (
        .row           (row_q),
        .col           (col_q),
        .dir           (move_t'(q.q_data)),
        .next_row      (next_row),
        .next_col      (next_col),
        .out_of_bounds (out_of_bounds)
    );

    assign start_ok      = len_is_legal(path_len, MAX_LEN);
    assign path_finished = (count_q == len_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            goal_row_q <= '0;
            goal_col_q <= '0;
            len_q      <= '0;
            count_q    <= '0;
            reached_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            goal_row_q <= goal_row_d;
            goal_col_q <= goal_col_d;
            len_q      <= len_d;
            count_q    <= count_d;
            reached_q  <= reached_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = start_ok ? ST_INIT : ST_ERR;
            ST_INIT:  state_d = ST_LOAD;
            ST_LOAD:  state_d = q.q_full ? ST_ERR : ST_REQ;
            ST_REQ: begin
                if (path_finished)  state_d = ST_FIN;
                else if (q.q_empty) state_d = ST_ERR;
                else                state_d = ST_APPLY;
            end
            ST_APPLY: state_d = out_of_bounds ? ST_ERR : ST_REQ;
            ST_FIN:   state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath registers: latched on an accepted start, advanced by each legal move.
    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        goal_row_d = goal_row_q;
        goal_col_d = goal_col_q;
        len_d      = len_q;
        count_d    = count_q;
        reached_d  = reached_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && start_ok) begin
                    row_d      = start_row;
                    col_d      = start_col;
                    goal_row_d = goal_row;
                    goal_col_d = goal_col;
                    len_d      = path_len;
                    count_d    = '0;
                    reached_d  = 1'b0;
                end else if (start) begin
                    len_d = '0;
                end
            end
            ST_APPLY: begin
                if (!out_of_bounds) begin
                    row_d   = next_row;
                    col_d   = next_col;
                    count_d = count_q + 1'b1;
                end
            end
            ST_FIN:  reached_d = (row_q == goal_row_q) && (col_q == goal_col_q);
            ST_ERR:  reached_d = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        q.q_init = (state_q == ST_INIT);
        q.q_load = (state_q == ST_LOAD);
        q.q_deq  = (state_q == ST_REQ) && !path_finished && !q.q_empty;
        step     = (state_q == ST_APPLY) && !out_of_bounds;
        done     = (state_q == ST_FIN);
        error    = (state_q == ST_ERR);
        // A rejected start clears the latched length, so q_back stays 0 in that case too.
        q.q_back = (state_q == ST_IDLE || len_q == '0) ? '0 : len_q - 1'b1;
    end

    assign row       = row_q;
    assign col       = col_q;
    assign reached   = reached_q;
    assign dbg_state = state_q;

endmodule
